// File: rtl/obs_ovl_pkg.sv
// -----------------------------------------------------------------------------
// obs_ovl_pkg
// Shared definitions for the serial overlap accumulator of the OBS GF(2^m)
// multiplier datapath.
//   T1_SEL..T4_SEL : term-select tag values carried on in_sel
//   state_t        : collector FSM state (COLLECT, FULL)
//   res_w()        : combined result width for a sub-product width w (2w+1)
// -----------------------------------------------------------------------------
package obs_ovl_pkg;

  localparam logic [1:0] T1_SEL = 2'd0;
  localparam logic [1:0] T2_SEL = 2'd1;
  localparam logic [1:0] T3_SEL = 2'd2;
  localparam logic [1:0] T4_SEL = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  function automatic int res_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/ovl_place.sv
// -----------------------------------------------------------------------------
// ovl_place
// Purely combinational placement of one sub-product term at its interleaved
// overlap position inside the (2W+1)-bit result.
//   T1[i] -> bit 2i, T2[i]/T3[i] -> bit 2i+1, T4[i] -> bit 2i+2
// Ports:
//   sel    in  2       term index (T1_SEL..T4_SEL)
//   data   in  W       term bits
//   placed out 2W+1    term shifted/interleaved into result position
// -----------------------------------------------------------------------------
module ovl_place
  import obs_ovl_pkg::*;
#(
  parameter int W = 59
) (
  input  logic [1:0]          sel,
  input  logic [W-1:0]        data,
  output logic [res_w(W)-1:0] placed
);

  always_comb begin
    // NOTE: every bit gets a default before the loop fills some of them, so
    // no path leaves placed unassigned and no latch is inferred.
    placed = '0;
    for (int i = 0; i < W; i++) begin
      case (sel)
        T1_SEL:         placed[2*i]   = data[i];
        T2_SEL, T3_SEL: placed[2*i+1] = data[i];
        default:        placed[2*i+2] = data[i];
      endcase
    end
  end

endmodule

// File: rtl/overlap_accum_serial.sv
// -----------------------------------------------------------------------------
// overlap_accum_serial
// Serial overlap combiner: collects the four Karatsuba sub-products T1..T4 as
// tagged words on one bus (any order), XOR-accumulates each at its overlap
// position and hands the (2W+1)-bit result to a one-entry output register
// with a valid/ready handshake. If the output register is still occupied when
// a frame completes, the full result is parked in acc (state FULL) and input
// is stalled until it can move out.
//
// Optional feature (macro OVL_DUP_ERR_EN): a term whose tag was already seen
// in the current frame is consumed without being accumulated and dup_err
// pulses for one cycle. Without the macro a repeated term is XORed in again
// and dup_err is tied 0.
//
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   clr        synchronous abort of the frame being collected
//   in_valid / in_ready / in_sel[SEL_W] / in_data[W]   term input
//   out_valid / out_ready / out_data[2W+1]             result output
//   dup_err    one-cycle duplicate-term pulse
// -----------------------------------------------------------------------------
module overlap_accum_serial
  import obs_ovl_pkg::*;
#(
  parameter int W     = 59,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic [W-1:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [res_w(W)-1:0] out_data,
  output logic                dup_err
);

  localparam int OW = res_w(W);

  state_t          state, state_n;
  logic [OW-1:0]   acc, acc_n;
  logic [3:0]      mask, mask_n;
  logic [OW-1:0]   placed;
  logic [OW-1:0]   contrib;
  logic [OW-1:0]   acc_sum;
  logic [3:0]      onehot;
  logic [3:0]      mask_sum;
  logic            accept;
  logic            out_free;
  logic            load;
  logic [OW-1:0]   load_data;

  ovl_place #(.W(W)) u_place (
    .sel    (in_sel),
    .data   (in_data),
    .placed (placed)
  );

  assign in_ready = (state == COLLECT) && !clr;
  assign accept   = in_valid && in_ready;
  assign onehot   = 4'b0001 << in_sel;
  assign mask_sum = mask | onehot;
  // The output register can take a new result if empty or draining this cycle.
  assign out_free = !out_valid || out_ready;

`ifdef OVL_DUP_ERR_EN
  logic dup;
  assign dup     = accept && mask[in_sel];
  assign contrib = dup ? '0 : placed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= dup;
  end
`else
  assign contrib = placed;
  assign dup_err = 1'b0;
`endif

  assign acc_sum = acc ^ contrib;

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mask_n    = mask;
    load      = 1'b0;
    load_data = acc;
    if (clr) begin
      // Abort wins over everything, including a parked result in FULL.
      state_n = COLLECT;
      acc_n   = '0;
      mask_n  = '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (mask_sum == 4'hF) begin
              if (out_free) begin
                load      = 1'b1;
                load_data = acc_sum;
                acc_n     = '0;
                mask_n    = '0;
              end else begin
                acc_n   = acc_sum;
                mask_n  = mask_sum;
                state_n = FULL;
              end
            end else begin
              acc_n  = acc_sum;
              mask_n = mask_sum;
            end
          end
        end
        FULL: begin
          if (out_free) begin
            load      = 1'b1;
            load_data = acc;
            acc_n     = '0;
            mask_n    = '0;
            state_n   = COLLECT;
          end
        end
        default: state_n = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      acc   <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mask  <= mask_n;
    end
  end

  // One-entry output register: reload has priority, so drain and reload in
  // the same cycle yields back-to-back results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
